// File: rtl/mac_tile_dual.sv
// ============================================================================
// Module   : mac_tile_dual
// Brief    : Dual-dataflow (WS/OS) systolic MAC processing element.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_tile_dual #(
  parameter int bw         = 4,
  parameter int psum_bw    = 16,
  parameter int act_signed = 0,
  parameter int sat_en     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s
);

  localparam logic [psum_bw-1:0] c_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] c_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic [bw-1:0]      r_a;
  logic [bw-1:0]      r_b;
  logic [psum_bw-1:0] r_c;
  logic [psum_bw-1:0] r_acc;
  logic [psum_bw-1:0] r_out_s;
  logic [2:0]         r_inst;
  logic               r_load_ready;
  logic               r_drain_first;
  logic               r_valid;
  logic               r_mode;

  logic signed [psum_bw-1:0] w_a_ext;
  logic signed [psum_bw-1:0] w_b_ext;
  logic signed [psum_bw-1:0] w_prod;
  logic signed [psum_bw:0]   w_sum;
  logic [psum_bw-1:0]        w_acc_next;
  logic [psum_bw-1:0]        w_w_sext;
  logic                      w_a_load;

  assign w_a_ext = (act_signed != 0) ? {{(psum_bw-bw){r_a[bw-1]}}, r_a}
                                     : {{(psum_bw-bw){1'b0}}, r_a};
  assign w_b_ext = {{(psum_bw-bw){r_b[bw-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // One extra bit exposes signed overflow of the OS accumulate.
  assign w_sum = {r_acc[psum_bw-1], r_acc} + {w_prod[psum_bw-1], w_prod};

  always_comb begin
    w_acc_next = r_acc;
    if (r_valid) begin
      if ((sat_en != 0) && (w_sum[psum_bw] != w_sum[psum_bw-1]))
        w_acc_next = w_sum[psum_bw] ? c_min : c_max;
      else
        w_acc_next = w_sum[psum_bw-1:0];
    end
  end

  assign w_w_sext = {{(psum_bw-bw){in_n[bw-1]}}, in_n[bw-1:0]};
  // In OS a drain suppresses any concurrent execute, including the activation capture.
  assign w_a_load = (inst_w[0] | inst_w[1]) & ~(mode & inst_w[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_acc         <= '0;
      r_out_s       <= '0;
      r_inst        <= '0;
      r_load_ready  <= 1'b1;
      r_drain_first <= 1'b1;
      r_valid       <= 1'b0;
      r_mode        <= mode;
    end else begin
      r_mode    <= mode;
      r_inst[1] <= inst_w[1];
      r_inst[2] <= inst_w[2];
      if (w_a_load)
        r_a <= in_w;

      if (mode != r_mode) begin
        r_acc     <= '0;
        r_c       <= '0;
        r_valid   <= 1'b0;
        r_inst[0] <= 1'b0;
      end else if (!mode) begin
        r_c       <= in_n;
        r_valid   <= 1'b0;
        r_inst[0] <= r_load_ready ? 1'b0 : inst_w[0];
        if (inst_w[2]) begin
          r_load_ready <= 1'b1;
        end else if (inst_w[0] && r_load_ready) begin
          r_b          <= in_w;
          r_load_ready <= 1'b0;
        end
      end else begin
        r_inst[0] <= 1'b0;
        r_valid   <= inst_w[1] & ~inst_w[2];
        if (inst_w[2]) begin
          if (r_drain_first) begin
            r_out_s       <= w_acc_next;
            r_acc         <= '0;
            r_drain_first <= 1'b0;
          end else begin
            r_out_s <= in_n;
            r_acc   <= w_acc_next;
          end
        end else begin
          r_drain_first <= 1'b1;
          r_acc         <= w_acc_next;
          if (inst_w[1]) begin
            r_b     <= in_n[bw-1:0];
            r_out_s <= w_w_sext;
          end
        end
      end
    end
  end

  assign out_e  = r_a;
  assign inst_e = r_inst;
  assign out_s  = r_mode ? r_out_s : (w_prod + r_c);

endmodule

`default_nettype wire
